// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct codes, ALU control encodings,
// the registered control bundle and its bubble value.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0c;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_SLT     = 6'h2a;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_t;

   typedef struct packed {
      logic      reg_write;
      logic      mem_to_reg;
      logic      mem_write;
      logic      alu_src;
      logic      reg_dst;
      logic      syscall;
      alu_ctrl_t alu_ctrl;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // R-type funct to ALU operation; unrecognised functs fall back to add
   function automatic alu_ctrl_t alu_from_funct(input logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// NREG x XLEN register file, two combinational read ports with write-through,
// two write ports. Port 2 (link) overrides port 1 (writeback) on the same register.
module regfile_bypass #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we1,
   input  logic [4:0]      wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic            we2,
   input  logic [4:0]      wa2,
   input  logic [XLEN-1:0] wd2
);

   localparam int         AW     = $clog2(NREG);
   localparam logic [5:0] NREG_W = 6'(NREG);

   logic [XLEN-1:0] regs [NREG];

   function automatic logic in_range(input logic [4:0] a);
      return ({1'b0, a} < NREG_W);
   endfunction

   // Register writes; r0 is never written, and the link port's assignment comes last so it wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (we1 && wa1 != 5'd0 && in_range(wa1)) regs[wa1[AW-1:0]] <= wd1;
         if (we2 && wa2 != 5'd0 && in_range(wa2)) regs[wa2[AW-1:0]] <= wd2;
      end
   end

   // Read port 1 with write-through, link data taking precedence over writeback
   always_comb begin
      rd1 = '0;
      if (ra1 != 5'd0 && in_range(ra1)) begin
         if (we2 && wa2 == ra1)      rd1 = wd2;
         else if (we1 && wa1 == ra1) rd1 = wd1;
         else                        rd1 = regs[ra1[AW-1:0]];
      end
   end

   // Read port 2, same bypass rules as port 1
   always_comb begin
      rd2 = '0;
      if (ra2 != 5'd0 && in_range(ra2)) begin
         if (we2 && wa2 == ra2)      rd2 = wd2;
         else if (we1 && wa1 == ra2) rd2 = wd1;
         else                        rd2 = regs[ra2[AW-1:0]];
      end
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage with ID/EX register: regfile read, branch/jump resolution with
// forwarding, jal link write, and hold/flush/bubble control of the ID/EX register.
// Optional feature: define DECODE_BNE_EN to decode bne (opcode 6'h05).
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   parameter  int NFWD = 2,
   localparam int FSW  = $clog2(NFWD + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instr_d,
   input  logic [XLEN-1:0]      pc_plus_4_d,
   input  logic                 valid_d,
   input  logic                 hold_e,
   input  logic                 flush_e,
   input  logic                 reg_write_w,
   input  logic [4:0]           write_reg_w,
   input  logic [XLEN-1:0]      write_data_w,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic [FSW-1:0]       fwd_sel_a,
   input  logic [FSW-1:0]       fwd_sel_b,
   output logic                 pc_src_d,
   output logic [XLEN-1:0]      branch_addr_d,
   output logic                 jump_d,
   output logic                 jr_d,
   output logic [XLEN-1:0]      jump_addr_d,
   output logic [XLEN-1:0]      jr_addr_d,
   output logic                 valid_e,
   output logic                 reg_write_e,
   output logic                 mem_to_reg_e,
   output logic                 mem_write_e,
   output logic                 alu_src_e,
   output logic                 reg_dst_e,
   output logic                 syscall_e,
   output logic [2:0]           alu_ctrl_e,
   output logic [XLEN-1:0]      rd1_e,
   output logic [XLEN-1:0]      rd2_e,
   output logic [XLEN-1:0]      sign_imm_e,
   output logic [4:0]           rs_e,
   output logic [4:0]           rt_e,
   output logic [4:0]           rd_e
);

   logic [5:0]      op, funct;
   logic [4:0]      rs, rt, rd;
   logic [XLEN-1:0] sign_imm, rd1, rd2, op_a, op_b, link_data;
   logic            is_beq, is_bne, is_jump, is_jr, go, link_we;
   ctrl_t           ctrl_d, ctrl_e;

   assign op       = instr_d[31:26];
   assign rs       = instr_d[25:21];
   assign rt       = instr_d[20:16];
   assign rd       = instr_d[15:11];
   assign funct    = instr_d[5:0];
   assign sign_imm = {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};

   // A stalled or invalid instruction may neither redirect fetch nor write the link register
   assign go        = valid_d & ~hold_e;
   assign link_we   = go & (op == OP_JAL);
   assign link_data = pc_plus_4_d + XLEN'(4);

   regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rd1),
      .rd2   (rd2),
      .we1   (reg_write_w),
      .wa1   (write_reg_w),
      .wd1   (write_data_w),
      .we2   (link_we),
      .wa2   (5'(NREG - 1)),
      .wd2   (link_data)
   );

   // Main control decode; unknown opcodes leave every enable at zero
   always_comb begin
      ctrl_d  = CTRL_BUBBLE;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_jump = 1'b0;
      is_jr   = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_JR:      is_jr = 1'b1;
               FN_SYSCALL: ctrl_d.syscall = 1'b1;
               default: begin
                  ctrl_d.reg_write = 1'b1;
                  ctrl_d.reg_dst   = 1'b1;
                  ctrl_d.alu_ctrl  = alu_from_funct(funct);
               end
            endcase
         end
         OP_LW: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.alu_ctrl   = ALU_ADD;
         end
         OP_SW: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_ctrl  = ALU_ADD;
         end
         OP_ADDI: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_ctrl  = ALU_ADD;
         end
         OP_BEQ: begin
            is_beq          = 1'b1;
            ctrl_d.alu_ctrl = ALU_SUB;
         end
`ifdef DECODE_BNE_EN
         OP_BNE: begin
            is_bne          = 1'b1;
            ctrl_d.alu_ctrl = ALU_SUB;
         end
`endif
         OP_J, OP_JAL: is_jump = 1'b1;
         default: ;
      endcase
   end

   // Comparator operand selection; selects beyond NFWD fall back to the regfile value
   always_comb begin
      op_a = rd1;
      op_b = rd2;
      for (int k = 0; k < NFWD; k++) begin
         if (fwd_sel_a == FSW'(k + 1)) op_a = fwd_data[k*XLEN +: XLEN];
         if (fwd_sel_b == FSW'(k + 1)) op_b = fwd_data[k*XLEN +: XLEN];
      end
   end

   assign pc_src_d      = go & ((is_beq & (op_a == op_b)) | (is_bne & (op_a != op_b)));
   assign jump_d        = go & is_jump;
   assign jr_d          = go & is_jr;
   assign branch_addr_d = pc_plus_4_d + (sign_imm << 2);
   assign jump_addr_d   = {pc_plus_4_d[XLEN-1:28], instr_d[25:0], 2'b00};
   assign jr_addr_d     = op_a;

   // ID/EX register: flush beats hold, hold beats an incoming bubble, otherwise load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_e    <= 1'b0;
         ctrl_e     <= CTRL_BUBBLE;
         rd1_e      <= '0;
         rd2_e      <= '0;
         sign_imm_e <= '0;
         rs_e       <= '0;
         rt_e       <= '0;
         rd_e       <= '0;
      end else if (flush_e || (!hold_e && !valid_d)) begin
         valid_e    <= 1'b0;
         ctrl_e     <= CTRL_BUBBLE;
         rd1_e      <= '0;
         rd2_e      <= '0;
         sign_imm_e <= '0;
         rs_e       <= '0;
         rt_e       <= '0;
         rd_e       <= '0;
      end else if (!hold_e) begin
         valid_e    <= 1'b1;
         ctrl_e     <= ctrl_d;
         rd1_e      <= rd1;
         rd2_e      <= rd2;
         sign_imm_e <= sign_imm;
         rs_e       <= rs;
         rt_e       <= rt;
         rd_e       <= rd;
      end
   end

   assign reg_write_e  = ctrl_e.reg_write;
   assign mem_to_reg_e = ctrl_e.mem_to_reg;
   assign mem_write_e  = ctrl_e.mem_write;
   assign alu_src_e    = ctrl_e.alu_src;
   assign reg_dst_e    = ctrl_e.reg_dst;
   assign syscall_e    = ctrl_e.syscall;
   assign alu_ctrl_e   = ctrl_e.alu_ctrl;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: a reference model predicts decode
// outputs and the next ID/EX contents, which are queued and compared after the edge.
module tb_decode_stage_pipe;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NFWD = 2;
`ifdef DECODE_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [8:0]  ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } ide_t;

   logic        clk, rst_n;
   logic [31:0] instr_d, pc_plus_4_d, write_data_w, branch_addr_d, jump_addr_d, jr_addr_d;
   logic        valid_d, hold_e, flush_e, reg_write_w;
   logic [4:0]  write_reg_w;
   logic [63:0] fwd_data;
   logic [1:0]  fwd_sel_a, fwd_sel_b;
   logic        pc_src_d, jump_d, jr_d, valid_e;
   logic        reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, syscall_e;
   logic [2:0]  alu_ctrl_e;
   logic [31:0] rd1_e, rd2_e, sign_imm_e;
   logic [4:0]  rs_e, rt_e, rd_e;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mregs [32];
   ide_t        exp_state;
   ide_t        sb_q [$];
   logic        last_pc_src, last_jump, last_jr;
   logic [31:0] last_branch_addr, last_jr_addr;

   decode_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) dut (
      .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_plus_4_d(pc_plus_4_d),
      .valid_d(valid_d), .hold_e(hold_e), .flush_e(flush_e),
      .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .write_data_w(write_data_w),
      .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .pc_src_d(pc_src_d), .branch_addr_d(branch_addr_d), .jump_d(jump_d), .jr_d(jr_d),
      .jump_addr_d(jump_addr_d), .jr_addr_d(jr_addr_d), .valid_e(valid_e),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
      .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e), .syscall_e(syscall_e),
      .alu_ctrl_e(alu_ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e),
      .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a stuck simulation
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, syscall, alu_ctrl}
   function automatic logic [8:0] exp_ctrl(input logic [31:0] instr);
      logic [5:0] op, fn;
      op = instr[31:26];
      fn = instr[5:0];
      case (op)
         6'h00: begin
            case (fn)
               6'h20:   return 9'b100010_010;
               6'h22:   return 9'b100010_110;
               6'h24:   return 9'b100010_000;
               6'h25:   return 9'b100010_001;
               6'h2a:   return 9'b100010_111;
               6'h08:   return 9'b000000_000;
               6'h0c:   return 9'b000001_000;
               default: return 9'b100010_010;
            endcase
         end
         6'h23:   return 9'b110100_010;
         6'h2b:   return 9'b001100_010;
         6'h08:   return 9'b100100_010;
         6'h04:   return 9'b000000_110;
         6'h05:   return BNE_EN ? 9'b000000_110 : 9'b0;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a, input logic wb_en,
                                         input logic [4:0] wb_reg, input logic [31:0] wb_data,
                                         input logic link_we, input logic [31:0] link_data);
      if (a == 5'd0) return 32'd0;
      if (link_we && a == 5'd31) return link_data;
      if (wb_en && wb_reg == a) return wb_data;
      return mregs[a];
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // One decode cycle: drive, check decode outputs, queue expected ID/EX, clock, compare
   task automatic applyStimulus(input string name, input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid, input logic hold, input logic flush,
                                input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_data,
                                input logic [1:0] sel_a, input logic [1:0] sel_b, input logic [63:0] fwd);
      logic [5:0]  op;
      logic [31:0] imm, r1v, r2v, a, b, link_data;
      logic        go, link_we, beq, bne, e_pc_src, e_jump, e_jr;
      ide_t        nxt, got;
      instr_d      = instr;
      pc_plus_4_d  = pc4;
      valid_d      = valid;
      hold_e       = hold;
      flush_e      = flush;
      reg_write_w  = wb_en;
      write_reg_w  = wb_reg;
      write_data_w = wb_data;
      fwd_sel_a    = sel_a;
      fwd_sel_b    = sel_b;
      fwd_data     = fwd;
      #4;
      op        = instr[31:26];
      imm       = {{16{instr[15]}}, instr[15:0]};
      go        = valid && !hold;
      link_we   = go && op == 6'h03;
      link_data = pc4 + 32'd4;
      r1v = mread(instr[25:21], wb_en, wb_reg, wb_data, link_we, link_data);
      r2v = mread(instr[20:16], wb_en, wb_reg, wb_data, link_we, link_data);
      a = (sel_a == 2'd1) ? fwd[31:0] : (sel_a == 2'd2) ? fwd[63:32] : r1v;
      b = (sel_b == 2'd1) ? fwd[31:0] : (sel_b == 2'd2) ? fwd[63:32] : r2v;
      beq      = op == 6'h04;
      bne      = BNE_EN && op == 6'h05;
      e_pc_src = go && ((beq && a == b) || (bne && a != b));
      e_jump   = go && (op == 6'h02 || op == 6'h03);
      e_jr     = go && op == 6'h00 && instr[5:0] == 6'h08;
      last_pc_src      = pc_src_d;
      last_jump        = jump_d;
      last_jr          = jr_d;
      last_branch_addr = branch_addr_d;
      last_jr_addr     = jr_addr_d;
      checkOutput({name, ".pc_src"}, {63'b0, pc_src_d}, {63'b0, e_pc_src});
      checkOutput({name, ".jump"}, {63'b0, jump_d}, {63'b0, e_jump});
      checkOutput({name, ".jr"}, {63'b0, jr_d}, {63'b0, e_jr});
      checkOutput({name, ".branch_addr"}, {32'b0, branch_addr_d}, {32'b0, pc4 + (imm << 2)});
      checkOutput({name, ".jump_addr"}, {32'b0, jump_addr_d}, {32'b0, pc4[31:28], instr[25:0], 2'b00});
      checkOutput({name, ".jr_addr"}, {32'b0, jr_addr_d}, {32'b0, a});
      if (flush || (!hold && !valid)) nxt = '0;
      else if (hold)                  nxt = exp_state;
      else nxt = '{valid: 1'b1, ctrl: exp_ctrl(instr), rd1: r1v, rd2: r2v, imm: imm,
                   rs: instr[25:21], rt: instr[20:16], rd: instr[15:11]};
      sb_q.push_back(nxt);
      @(posedge clk);
      #1;
      if (wb_en && wb_reg != 5'd0) mregs[wb_reg] = wb_data;
      if (link_we) mregs[31] = link_data;
      exp_state = nxt;
      if (sb_q.size() == 0) begin
         checkOutput({name, ".scoreboard"}, 64'd0, 64'd1);
      end else begin
         got = sb_q.pop_front();
         checkOutput({name, ".ctrl_e"},
                     {54'b0, valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e,
                      reg_dst_e, syscall_e, alu_ctrl_e}, {54'b0, got.valid, got.ctrl});
         checkOutput({name, ".rd1_e"}, {32'b0, rd1_e}, {32'b0, got.rd1});
         checkOutput({name, ".rd2_e"}, {32'b0, rd2_e}, {32'b0, got.rd2});
         checkOutput({name, ".imm_e"}, {32'b0, sign_imm_e}, {32'b0, got.imm});
         checkOutput({name, ".fields_e"}, {49'b0, rs_e, rt_e, rd_e}, {49'b0, got.rs, got.rt, got.rd});
      end
   endtask

   task automatic dec(input string name, input logic [31:0] instr, input logic [31:0] pc4);
      applyStimulus(name, instr, pc4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 64'd0);
   endtask

   task automatic wb(input string name, input logic [4:0] r, input logic [31:0] d);
      applyStimulus(name, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, r, d, 2'd0, 2'd0, 64'd0);
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, ".ctrl"}, {54'b0, valid_e, reg_write_e, mem_to_reg_e, mem_write_e,
                  alu_src_e, reg_dst_e, syscall_e, alu_ctrl_e}, 64'd0);
      checkOutput({name, ".data"}, {rd1_e, rd2_e} | {sign_imm_e, 17'b0, rs_e, rt_e, rd_e}, 64'd0);
   endtask

   // Main stimulus sequence
   initial begin
      logic [31:0] rnd_pc, rnd_d, rnd_i;
      logic [5:0]  fns [6];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      exp_state = '0;
      rst_n = 1'b0;
      instr_d = '0; pc_plus_4_d = '0; valid_d = 1'b0; hold_e = 1'b0; flush_e = 1'b0;
      reg_write_w = 1'b0; write_reg_w = '0; write_data_w = '0;
      fwd_data = '0; fwd_sel_a = '0; fwd_sel_b = '0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      rst_n = 1'b1;

      wb("wb_r1", 5'd1, 32'd7);
      wb("wb_r2", 5'd2, 32'd9);
      wb("wb_r3", 5'd3, 32'd3);
      wb("wb_r4", 5'd4, 32'd4);
      wb("wb_r0_ignored", 5'd0, 32'hffff_ffff);

      applyStimulus("wt_r5", rtype(6'h20, 5'd5, 5'd0, 5'd6), 32'h10, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd5, 32'h1234, 2'd0, 2'd0, 64'd0);
      checkOutput("wt_r5.direct", {32'b0, rd1_e}, 64'h1234);

      applyStimulus("beq_fwd", itype(6'h04, 5'd1, 5'd2, 16'd3), 32'h100, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'd0, 2'd0, 2'd1, {32'd0, 32'd7});
      checkOutput("beq_fwd.taken", {63'b0, last_pc_src}, 64'd1);
      checkOutput("beq_fwd.target", {32'b0, last_branch_addr}, 64'h10c);

      dec("beq_nottaken", itype(6'h04, 5'd1, 5'd2, 16'hfffe), 32'h200);
      checkOutput("beq_nottaken.direct", {63'b0, last_pc_src}, 64'd0);

      applyStimulus("beq_sel3", itype(6'h04, 5'd1, 5'd1, 16'd1), 32'h300, 1'b1, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'd0, 2'd3, 2'd0, {32'd5, 32'd6});

      applyStimulus("jal_link", {6'h03, 26'h0000_123}, 32'h40, 1'b1, 1'b0, 1'b0,
                    1'b1, 5'd31, 32'hdead, 2'd0, 2'd0, 64'd0);
      dec("jr_r31", rtype(6'h08, 5'd31, 5'd0, 5'd0), 32'h80);
      checkOutput("jr_r31.link", {32'b0, last_jr_addr}, 64'h44);
      checkOutput("jr_r31.taken", {63'b0, last_jr}, 64'd1);

      dec("lw", itype(6'h23, 5'd1, 5'd8, 16'h8004), 32'h84);
      applyStimulus("flush_hold", itype(6'h2b, 5'd2, 5'd3, 16'd8), 32'h88, 1'b1, 1'b1, 1'b1,
                    1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 64'd0);
      checkOutput("flush_hold.valid", {62'b0, valid_e, reg_write_e}, 64'd0);

      dec("addi", itype(6'h08, 5'd1, 5'd7, 16'd5), 32'h90);
      applyStimulus("hold1", {6'h03, 26'h3ff_ffff}, 32'h94, 1'b1, 1'b1, 1'b0,
                    1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 64'd0);
      checkOutput("hold1.nojump", {63'b0, last_jump}, 64'd0);
      applyStimulus("hold2", {6'h02, 26'h155_5555}, 32'h98, 1'b1, 1'b1, 1'b0,
                    1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 64'd0);
      checkOutput("hold2.addi_kept", {32'b0, sign_imm_e}, 64'd5);
      dec("jr_after_hold", rtype(6'h08, 5'd31, 5'd0, 5'd0), 32'h9c);
      checkOutput("jr_after_hold.nolink", {32'b0, last_jr_addr}, 64'h44);

      dec("bne", itype(6'h05, 5'd3, 5'd4, 16'd2), 32'ha0);
      checkOutput("bne.direct", {63'b0, last_pc_src}, {63'b0, BNE_EN});
      checkOutput("bne.valid_e", {63'b0, valid_e}, 64'd1);

      dec("sw", itype(6'h2b, 5'd3, 5'd4, 16'hfff0), 32'ha4);
      dec("syscall", rtype(6'h0c, 5'd0, 5'd0, 5'd0), 32'ha8);
      dec("unknown", itype(6'h3f, 5'd1, 5'd2, 16'h1111), 32'hac);
      checkOutput("unknown.valid", {63'b0, valid_e}, 64'd1);
      dec("j", {6'h02, 26'h0abc_def}, 32'hf000_0010);
      applyStimulus("bubble", rtype(6'h20, 5'd1, 5'd2, 5'd3), 32'hb0, 1'b0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 64'd0);

      // Mid-stream reset: registers and ID/EX clear, decoding resumes next cycle
      rst_n = 1'b0;
      #2;
      checkResetState("mid_reset");
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      exp_state = '0;
      sb_q.delete();
      #1;
      rst_n = 1'b1;
      dec("post_reset", rtype(6'h20, 5'd1, 5'd2, 5'd8), 32'hc0);
      checkOutput("post_reset.r1_cleared", {32'b0, rd1_e}, 64'd0);

      for (int n = 0; n < 24; n++) begin
         rnd_pc = $urandom;
         rnd_d  = $urandom;
         rnd_i  = rtype(fns[$urandom_range(0, 5)], 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) rnd_i = itype(6'h04, rnd_i[25:21], rnd_i[20:16], rnd_d[15:0]);
         applyStimulus("rand", rnd_i, {rnd_pc[31:2], 2'b00},
                       1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), rnd_d,
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
